load_store_unit: RTL

Memory-access stage of the RV32I datapath. Accepts one load or store per request from execute and drives a word-wide data-memory port with a valid/ready request channel and a variable-latency read-response channel. Aligns and sign- or zero-extends load data. Produces the register-file write port (we3, a3, wd3) for loads.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Bundle of the execute request, data-memory and register-file write signals
// that the load/store unit connects to.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        fault;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
        output we3, a3, wd3, fault
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
        input  we3, a3, wd3, fault
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one load/store in flight, lane steering for stores,
// alignment and sign/zero extension for loads, register-file write port.
//
// state  | meaning
// IDLE   | ready for a request from execute
// REQ    | memory request presented, waiting for mem_ready
// WAIT   | load issued, waiting for mem_rvalid
// WB     | one-cycle register-file write of the extended load data
// FLT    | one-cycle fault pulse for an illegal access
module load_store_unit (
    input  logic clk,
    input  logic rst_n,
    load_store_unit_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;

    logic [2:0]  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;

    logic        accept;
    logic        funct3_ok;
    logic        misaligned;
    logic        illegal;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign bus.req_ready = rst_n && (state == S_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        funct3_ok = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = !bus.req_we;
            default:                funct3_ok = 1'b0;
        endcase
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        illegal = !funct3_ok || misaligned;
    end

    // Store lanes: data is replicated so the byte enables alone select the lane.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << bus.req_addr[1:0];
                wdata_next = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << bus.req_addr[1:0];
                wdata_next = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = bus.req_wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel  = bus.mem_rdata[{off_q, 3'b000} +: 8];
        half_sel  = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
        load_data = bus.mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
            rd_q          <= 5'd0;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'b0000;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.we3       <= 1'b0;
            bus.a3        <= 5'd0;
            bus.wd3       <= 32'h0;
            bus.fault     <= 1'b0;
        end else begin
            bus.we3   <= 1'b0;
            bus.fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        off_q    <= bus.req_addr[1:0];
                        rd_q     <= bus.req_rd;
                        if (illegal) begin
                            state     <= S_FLT;
                            bus.fault <= 1'b1;
                        end else begin
                            state         <= S_REQ;
                            bus.mem_valid <= 1'b1;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_be    <= bus.req_we ? be_next : 4'b1111;
                            bus.mem_wdata <= wdata_next;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        state         <= we_q ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        state   <= S_WB;
                        bus.we3 <= (rd_q != 5'd0);
                        bus.a3  <= rd_q;
                        bus.wd3 <= load_data;
                    end
                end
                S_WB:    state <= S_IDLE;
                S_FLT:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
